countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_if.sv | 23 ++
 rtl/countdown_timer.sv | 108 ++++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for the mm:ss countdown timer.
interface countdown_timer_if;
  logic        tick;
  logic        load;
  logic        start;
  logic        stop;
  logic [15:0] preset;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        expire;
  logic        load_err;

  modport master (
    output tick, load, start, stop, preset,
    input  digits, running, done, expire, load_err
  );

  modport slave (
    input  tick, load, start, stop, preset,
    output digits, running, done, expire, load_err
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with load/start/stop control and registered status.
module countdown_timer #(
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  tmr
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] digits_q, digits_n;
  logic        expire_q, expire_n;
  logic        load_err_q, load_err_n;
  logic        running_q, done_q;
  logic        preset_ok;
  logic [15:0] dec_val;

  // Range check of every preset digit against its legal maximum.
  always_comb begin
    preset_ok = (tmr.preset[3:0]   <= 4'd9) &&
                (tmr.preset[7:4]   <= 4'd5) &&
                (tmr.preset[11:8]  <= 4'd9) &&
                (tmr.preset[15:12] <= 4'(MIN_TENS_MAX));
  end

  // One-second BCD decrement; each digit wraps and borrows only when all lower digits are zero.
  always_comb begin
    dec_val = digits_q;
    if (digits_q[3:0] != 4'd0) begin
      dec_val[3:0] = digits_q[3:0] - 4'd1;
    end else begin
      dec_val[3:0] = 4'd9;
      if (digits_q[7:4] != 4'd0) begin
        dec_val[7:4] = digits_q[7:4] - 4'd1;
      end else begin
        dec_val[7:4] = 4'd5;
        if (digits_q[11:8] != 4'd0) begin
          dec_val[11:8] = digits_q[11:8] - 4'd1;
        end else begin
          dec_val[11:8]  = 4'd9;
          dec_val[15:12] = digits_q[15:12] - 4'd1;
        end
      end
    end
  end

  // Next-state and next-output decode; load has priority over start in IDLE/PAUSE.
  always_comb begin
    state_n    = state;
    digits_n   = digits_q;
    expire_n   = 1'b0;
    load_err_n = 1'b0;
    unique case (state)
      RUN: begin
        if (tmr.stop) begin
          state_n = PAUSE;
        end else if (tmr.tick) begin
          digits_n = dec_val;
          if (digits_q == 16'h0001) begin
            state_n  = DONE;
            expire_n = 1'b1;
          end
        end
      end
      IDLE, PAUSE, DONE: begin
        if (tmr.load) begin
          if (preset_ok) begin
            digits_n = tmr.preset;
            state_n  = IDLE;
          end else begin
            load_err_n = 1'b1;
          end
        end else if (tmr.start && state != DONE && digits_q != '0) begin
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; status flags are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      digits_q   <= '0;
      expire_q   <= 1'b0;
      load_err_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      digits_q   <= digits_n;
      expire_q   <= expire_n;
      load_err_q <= load_err_n;
      running_q  <= (state_n == RUN);
      done_q     <= (state_n == DONE);
    end
  end

  assign tmr.digits   = digits_q;
  assign tmr.running  = running_q;
  assign tmr.done     = done_q;
  assign tmr.expire   = expire_q;
  assign tmr.load_err = load_err_q;

endmodule
